axis_row_packer_fifo: RTL and testbench



---
 rtl/axis_row_packer_fifo_pkg.sv | 22 ++
 rtl/axis_row_packer_fifo_row_lane_writer.sv | 31 +++
 rtl/axis_row_packer_fifo.sv | 155 +++++++++++++++
 tb/tb_axis_row_packer_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_row_packer_fifo_pkg.sv
// Shared constants and helpers for the AXIS row packer FIFO.
// Default parameter values live here so the top and any bench agree on them.
package axis_row_packer_fifo_pkg;

  localparam int AXIS_DATA_WIDTH_DEF = 32;
  localparam int ELEM_WIDTH_DEF      = 5;
  localparam int ELEMS_PER_BEAT_DEF  = 6;
  localparam int MAC_NUM_DEF         = 256;
  localparam int DEPTH_DEF           = 4;
  localparam int ROW_WIDTH           = ELEM_WIDTH_DEF * MAC_NUM_DEF;
  localparam int LEN_W               = 13;  // one bit wider than elem_cnt

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_row_packer_fifo_row_lane_writer.sv
// Lane-enable and zero-fill masks for one accepted beat: which lanes take beat
// data and which lanes of a freshly started row are forced to zero.
module row_lane_writer
  import axis_row_packer_fifo_pkg::*;
#(
  parameter int MAC_NUM        = MAC_NUM_DEF,
  parameter int ELEMS_PER_BEAT = ELEMS_PER_BEAT_DEF
) (
  input  logic [11:0]        elem_cnt,
  input  logic [LEN_W-1:0]   eff_len,
  input  logic               first_beat,
  output logic [MAC_NUM-1:0] lane_en,
  output logic [MAC_NUM-1:0] lane_clr
);

  logic [LEN_W-1:0] win_lo;
  logic [LEN_W-1:0] win_hi;

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    lane_en  = '0;
    lane_clr = '0;
    win_lo   = {1'b0, elem_cnt};
    win_hi   = {1'b0, elem_cnt} + LEN_W'(ELEMS_PER_BEAT);
    for (int l = 0; l < MAC_NUM; l++) begin
      lane_en[l]  = (LEN_W'(l) >= win_lo) && (LEN_W'(l) < win_hi) && (LEN_W'(l) < eff_len);
      lane_clr[l] = first_beat && !lane_en[l];
    end
  end

endmodule

// File: rtl/axis_row_packer_fifo.sv
// Packs narrow AXIS beats of activations into full MAC rows and queues up to
// DEPTH committed rows with a valid/ready pop interface toward the MAC array.
module axis_row_packer_fifo
  import axis_row_packer_fifo_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
  parameter int ELEM_WIDTH      = ELEM_WIDTH_DEF,
  parameter int ELEMS_PER_BEAT  = ELEMS_PER_BEAT_DEF,
  parameter int MAC_NUM         = MAC_NUM_DEF,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int CNT_W           = clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          soft_clr,
  input  logic [11:0]                   cfg_row_elems,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [ELEM_WIDTH*MAC_NUM-1:0] row_data,
  output logic                          row_last,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [CNT_W-1:0]              fifo_cnt,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          cfg_err
);

  localparam int ROW_W  = ELEM_WIDTH * MAC_NUM;
  localparam int PTR_W  = clog2(DEPTH);
  localparam int BEAT_W = ELEM_WIDTH * ELEMS_PER_BEAT;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [11:0]      elem_cnt_q, elem_cnt_d;
  logic [LEN_W-1:0] eff_len_q, eff_len_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic [ROW_W-1:0] mem_q [DEPTH];
  logic             last_q [DEPTH];

  logic             pop, acc, commit, first_beat, cfg_bad, mem_we;
  logic [LEN_W-1:0] len_cur;
  logic [MAC_NUM-1:0] lane_en, lane_clr;
  logic [ROW_W-1:0] shifted, en_bits, clr_bits, row_wr_data;
  logic             unused_tdata_hi;

  assign unused_tdata_hi = ^s_axis_tdata[AXIS_DATA_WIDTH-1:BEAT_W];

  assign fifo_full     = (fifo_cnt_q == CNT_W'(DEPTH));
  assign fifo_empty    = (fifo_cnt_q == '0);
  assign row_valid     = ~fifo_empty;
  assign pop           = row_valid & row_ready;
  assign s_axis_tready = ~rst & (~fifo_full | pop);
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign first_beat    = (elem_cnt_q == '0);
  assign cfg_bad       = (cfg_row_elems == '0) || ({1'b0, cfg_row_elems} > LEN_W'(MAC_NUM));
  assign len_cur       = first_beat ? (cfg_bad ? LEN_W'(MAC_NUM) : {1'b0, cfg_row_elems})
                                    : eff_len_q;
  assign commit        = acc && ((({1'b0, elem_cnt_q} + LEN_W'(ELEMS_PER_BEAT)) >= len_cur)
                                 || s_axis_tlast);
  assign mem_we        = acc & ~soft_clr;

  row_lane_writer #(
    .MAC_NUM        (MAC_NUM),
    .ELEMS_PER_BEAT (ELEMS_PER_BEAT)
  ) u_lane_writer (
    .elem_cnt   (elem_cnt_q),
    .eff_len    (len_cur),
    .first_beat (first_beat),
    .lane_en    (lane_en),
    .lane_clr   (lane_clr)
  );

  // Beat elements are shifted to the fill position; the masks pick what lands.
  always_comb begin
    en_bits  = '0;
    clr_bits = '0;
    for (int l = 0; l < MAC_NUM; l++) begin
      en_bits[l*ELEM_WIDTH +: ELEM_WIDTH]  = {ELEM_WIDTH{lane_en[l]}};
      clr_bits[l*ELEM_WIDTH +: ELEM_WIDTH] = {ELEM_WIDTH{lane_clr[l]}};
    end
    shifted     = ROW_W'(s_axis_tdata[BEAT_W-1:0]) << (int'(elem_cnt_q) * ELEM_WIDTH);
    row_wr_data = (shifted & en_bits) | (mem_q[wr_ptr_q] & ~(en_bits | clr_bits));
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    elem_cnt_d = elem_cnt_q;
    eff_len_d  = eff_len_q;
    fifo_cnt_d = fifo_cnt_q;
    cfg_err_d  = cfg_err_q;
    if (soft_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      elem_cnt_d = '0;
      eff_len_d  = '0;
      fifo_cnt_d = '0;
      cfg_err_d  = 1'b0;
    end else begin
      if (acc) begin
        eff_len_d = len_cur;
        if (first_beat && cfg_bad) cfg_err_d = 1'b1;
        if (commit) begin
          elem_cnt_d = '0;
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        end else begin
          elem_cnt_d = elem_cnt_q + 12'(ELEMS_PER_BEAT);
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({commit, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments; _d values come from blocking always_comb logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      elem_cnt_q <= '0;
      eff_len_q  <= '0;
      fifo_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      elem_cnt_q <= elem_cnt_d;
      eff_len_q  <= eff_len_d;
      fifo_cnt_q <= fifo_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // NOTE: row storage has no reset; the first beat of every row zero-fills it and outputs are gated by row_valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q]  <= row_wr_data;
      last_q[wr_ptr_q] <= commit & s_axis_tlast;
    end
  end

  assign row_data = row_valid ? mem_q[rd_ptr_q] : '0;
  assign row_last = row_valid & last_q[rd_ptr_q];
  assign fifo_cnt = fifo_cnt_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_axis_row_packer_fifo.sv
// Directed bench for axis_row_packer_fifo: row packing, tlast commit, backpressure,
// pointer wrap, config error, soft clear and async reset mid-row.
module tb_axis_row_packer_fifo;
  import axis_row_packer_fifo_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 soft_clr;
  logic [11:0]          cfg_row_elems;
  logic [31:0]          s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic [ROW_WIDTH-1:0] row_data;
  logic                 row_last;
  logic                 row_valid;
  logic                 row_ready;
  logic [2:0]           fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_row_packer_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .soft_clr      (soft_clr),
    .cfg_row_elems (cfg_row_elems),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .row_data      (row_data),
    .row_last      (row_last),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .fifo_cnt      (fifo_cnt),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .cfg_err       (cfg_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element k of beat b: nonzero so padding is distinguishable, distinct within a beat.
  function automatic logic [4:0] elem(input int b, input int k);
    return 5'(((b * 6 + k) % 31) + 1);
  endfunction

  function automatic logic [31:0] mk_beat(input int b);
    logic [31:0] d;
    d = '1;  // upper ignored bits set to catch misuse
    for (int k = 0; k < 6; k++) d[k*5 +: 5] = elem(b, k);
    return d;
  endfunction

  // Row built from nb beats starting at beat b0, truncated to len lanes.
  function automatic logic [4:0] exp_lane(input int b0, input int nb, input int len, input int j);
    int lim;
    lim = (len < nb * 6) ? len : nb * 6;
    return (j < lim) ? elem(b0 + j / 6, j % 6) : 5'd0;
  endfunction

  task automatic check_row(input string tag, input int b0, input int nb, input int len,
                           input logic lst);
    check({tag, "_valid"}, row_valid, 1'b1);
    check({tag, "_last"}, row_last, lst);
    for (int j = 0; j < MAC_NUM_DEF; j++)
      check($sformatf("%s_lane%0d", tag, j), row_data[j*5 +: 5], exp_lane(b0, nb, len, j));
  endtask

  // Presents beat b until accepted; starts and ends just after a negedge.
  task automatic drive_beat(input int b, input logic lst);
    bit done;
    done = 1'b0;
    s_axis_tdata  = mk_beat(b);
    s_axis_tlast  = lst;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1 done = s_axis_tready;
      @(posedge clk);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check($sformatf("beat%0d_accepted", b), done, 1'b1);
  endtask

  task automatic pop_row(input string tag, input int b0, input int nb, input int len,
                         input logic lst);
    check_row(tag, b0, nb, len, lst);
    row_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    row_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("mon_cnt_le_depth", fifo_cnt <= 3'(DEPTH), 1'b1);
      check("mon_valid_vs_empty", row_valid, !fifo_empty);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  q[$];
  int  pushed, popped, idx;
  bit  accept, do_pop;

  initial begin
    rst = 1'b1; soft_clr = 1'b0; cfg_row_elems = 12'd256;
    s_axis_tdata = '0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; row_ready = 1'b0;
    #1;
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_cnt", fifo_cnt, 3'd0);
    check("rst_valid", row_valid, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_tready", s_axis_tready, 1'b1);
    check("init_empty", fifo_empty, 1'b1);
    check("init_full", fifo_full, 1'b0);
    @(negedge clk);

    // 1: full 256-element row from 43 beats, last beat's elements 4-5 dropped
    cfg_row_elems = 12'd256; row_ready = 1'b1;
    for (int b = 0; b < 43; b++) begin
      drive_beat(b, 1'b0);
      if (b == 41) check("t1_no_early_commit", fifo_cnt, 3'd0);
    end
    check("t1_cnt", fifo_cnt, 3'd1);
    check_row("t1_row", 0, 43, 256, 1'b0);
    @(negedge clk);
    check("t1_popped", fifo_cnt, 3'd0);

    // 2: tlast closes a 20-element row after 12 elements; zero padding
    cfg_row_elems = 12'd20;
    drive_beat(50, 1'b0);
    check("t2_not_committed", fifo_cnt, 3'd0);
    drive_beat(51, 1'b1);
    check("t2_cnt", fifo_cnt, 3'd1);
    check_row("t2_row", 50, 2, 20, 1'b1);
    @(negedge clk);
    check("t2_popped", fifo_cnt, 3'd0);

    // 3: backpressure at full, accept coincides with pop
    row_ready = 1'b0; cfg_row_elems = 12'd6;
    for (int b = 60; b < 64; b++) drive_beat(b, 1'b0);
    check("t3_cnt_full", fifo_cnt, 3'd4);
    check("t3_full", fifo_full, 1'b1);
    s_axis_tdata = mk_beat(64); s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_tready_low", s_axis_tready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    row_ready = 1'b1;
    #1 check("t3_tready_on_pop", s_axis_tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    row_ready = 1'b0; s_axis_tvalid = 1'b0;
    check("t3_cnt_held", fifo_cnt, 3'd4);
    pop_row("t3_r61", 61, 1, 6, 1'b0);
    pop_row("t3_r62", 62, 1, 6, 1'b0);
    pop_row("t3_r63", 63, 1, 6, 1'b0);
    pop_row("t3_r64", 64, 1, 6, 1'b0);
    drive_beat(65, 1'b0);
    pop_row("t3_r65", 65, 1, 6, 1'b0);
    check("t3_empty", fifo_empty, 1'b1);

    // 4: ten rows across pointer wrap with random consumer stalls
    cfg_row_elems = 12'd6; pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 10; cyc++) begin
      s_axis_tvalid = (pushed < 10);
      s_axis_tdata  = mk_beat(100 + pushed);
      s_axis_tlast  = (pushed % 2 == 1);
      row_ready     = (pushed == 10) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("t4_valid_when_empty", row_valid & fifo_empty, 1'b0);
      accept = s_axis_tvalid & s_axis_tready;
      do_pop = row_valid & row_ready;
      if (do_pop) begin
        check("t4_row_expected", q.size() > 0, 1'b1);
        idx = (q.size() > 0) ? q[0] : 0;
        check_row($sformatf("t4_row%0d", idx), 100 + idx, 1, 6, idx % 2 == 1);
      end
      @(posedge clk);
      if (do_pop && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (accept) begin
        q.push_back(pushed);
        pushed++;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; row_ready = 1'b0;
    check("t4_popped", popped, 10);
    check("t4_empty", fifo_empty, 1'b1);

    // 5: illegal length, then soft clear mid-row with two rows queued
    cfg_row_elems = 12'd0;
    for (int b = 200; b < 243; b++) begin
      drive_beat(b, 1'b0);
      if (b == 200) check("t5_cfg_err_set", cfg_err, 1'b1);
      if (b == 241) check("t5_no_early_commit", fifo_cnt, 3'd0);
    end
    check("t5_cnt1", fifo_cnt, 3'd1);
    check_row("t5_row", 200, 43, 256, 1'b0);
    cfg_row_elems = 12'd6;
    drive_beat(250, 1'b0);
    check("t5_cnt2", fifo_cnt, 3'd2);
    check("t5_cfg_err_sticky", cfg_err, 1'b1);
    cfg_row_elems = 12'd20;
    drive_beat(251, 1'b0);
    soft_clr = 1'b1; s_axis_tdata = mk_beat(252); s_axis_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    soft_clr = 1'b0; s_axis_tvalid = 1'b0;
    check("t5_clr_cnt", fifo_cnt, 3'd0);
    check("t5_clr_cfg_err", cfg_err, 1'b0);
    check("t5_clr_valid", row_valid, 1'b0);
    drive_beat(253, 1'b0);
    drive_beat(254, 1'b1);
    check("t5_cnt_after_clr", fifo_cnt, 3'd1);
    pop_row("t5_fresh", 253, 2, 20, 1'b1);

    // 6: async reset with a queued row and a partial row (elem_cnt=18)
    cfg_row_elems = 12'd300;
    drive_beat(300, 1'b1);
    check("t6_cfg_err", cfg_err, 1'b1);
    cfg_row_elems = 12'd20;
    for (int b = 301; b < 304; b++) drive_beat(b, 1'b0);
    check("t6_cnt_before", fifo_cnt, 3'd1);
    rst = 1'b1; s_axis_tdata = mk_beat(304); s_axis_tvalid = 1'b1;
    #1;
    check("t6_tready", s_axis_tready, 1'b0);
    check("t6_valid", row_valid, 1'b0);
    check("t6_cnt", fifo_cnt, 3'd0);
    check("t6_row_data_zero", |row_data, 1'b0);
    check("t6_row_last", row_last, 1'b0);
    check("t6_cfg_err_clr", cfg_err, 1'b0);
    check("t6_empty", fifo_empty, 1'b1);
    repeat (2) @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    drive_beat(310, 1'b0);
    drive_beat(311, 1'b1);
    check("t6_cnt_after", fifo_cnt, 3'd1);
    pop_row("t6_fresh", 310, 2, 20, 1'b1);
    check("t6_final_empty", fifo_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
